// File: rtl/time_of_day_counter_pkg.sv
// Shared definitions for the time-of-day counter.
//   - FSM state encoding (RUN / SET_HOUR / SET_MIN)
//   - blink mask patterns presented to the display stage
//   - BCD field moduli and digit limit
package time_of_day_counter_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET_HOUR = 2'd1;
    localparam logic [1:0] ST_SET_MIN  = 2'd2;

    typedef enum logic [1:0] {
        StRun     = ST_RUN,
        StSetHour = ST_SET_HOUR,
        StSetMin  = ST_SET_MIN
    } state_e;

    // Bit 5 = hour1 ... bit 0 = sec0; 1 blanks the digit.
    localparam logic [5:0] MASK_HOUR = 6'b110000;
    localparam logic [5:0] MASK_MIN  = 6'b001100;
    localparam logic [5:0] MASK_NONE = 6'b000000;

    localparam int unsigned SEC_MOD       = 60;
    localparam int unsigned MIN_MOD       = 60;
    localparam logic [3:0]  BCD_UNITS_MAX = 4'd9;

endpackage

// File: rtl/time_of_day_counter_if.sv
// Bundles the control inputs and display-facing outputs of the time-of-day counter.
//   master : drives tick/enable/mode_btn/inc_btn, observes digits, blink_mask, day_carry
//   slave  : the counter itself
interface time_of_day_counter_if;

    logic       tick;
    logic       enable;
    logic       mode_btn;
    logic       inc_btn;
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [5:0] blink_mask;
    logic       day_carry;

    modport master (
        output tick, enable, mode_btn, inc_btn,
        input  hour1, hour0, min1, min0, sec1, sec0, blink_mask, day_carry
    );

    modport slave (
        input  tick, enable, mode_btn, inc_btn,
        output hour1, hour0, min1, min0, sec1, sec0, blink_mask, day_carry
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter counting 00..MOD-1.
//   clk, reset : clock, synchronous active-high reset
//   inc        : advance by one (wraps MOD-1 -> 00)
//   clr        : force 00 (takes priority over inc)
//   tens/units : registered BCD digits
//   wrap       : combinational, high when this inc wraps the counter (carry to next field)
module bcd_mod_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int unsigned MOD = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       wrap
);

    localparam logic [3:0] TENS_MAX  = 4'((MOD - 1) / 10);
    localparam logic [3:0] UNITS_MAX = 4'((MOD - 1) % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic       at_max;

    always_comb begin
        at_max  = (tens_q == TENS_MAX) && (units_q == UNITS_MAX);
        wrap    = inc && at_max && !clr;
        tens_d  = tens_q;
        units_d = units_q;
        if (clr) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
        end else if (inc) begin
            if (at_max) begin
                tens_d  = 4'd0;
                units_d = 4'd0;
            end else if (units_q == BCD_UNITS_MAX) begin
                tens_d  = tens_q + 4'd1;
                units_d = 4'd0;
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tens_q  <= 4'd0;
            units_q <= 4'd0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;

endmodule

// File: rtl/time_of_day_counter.sv
// HH:MM:SS BCD time-of-day counter with button-driven set mode.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of time_of_day_counter_if
//                inputs  tick, enable, mode_btn, inc_btn
//                outputs six BCD digits, blink_mask, day_carry (all registered)
//   HOUR_MOD   : hour modulus (12..24)
module time_of_day_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int unsigned HOUR_MOD = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    time_of_day_counter_if.slave bus
);

    state_e     state_q, state_d;
    logic       mode_hist_q, inc_hist_q;
    logic       phase_q, phase_d;
    logic [5:0] mask_q, mask_d;
    logic       day_carry_q, day_carry_d;

    logic mode_edge, inc_edge, in_run;
    logic run_adv, sec_clr, min_inc, hour_inc;
    logic sec_wrap, min_wrap, hour_wrap;

    always_comb begin
        mode_edge = bus.mode_btn && !mode_hist_q;
        inc_edge  = bus.inc_btn && !inc_hist_q;
        in_run    = (state_q == StRun);

        // A mode edge out of RUN swallows a coincident tick.
        run_adv  = in_run && bus.tick && bus.enable && !mode_edge;
        sec_clr  = in_run && mode_edge;
        // Carry chaining only in RUN; set increments wrap without carry.
        min_inc  = sec_wrap || ((state_q == StSetMin) && inc_edge && !mode_edge);
        hour_inc = (in_run && min_wrap) || ((state_q == StSetHour) && inc_edge && !mode_edge);

        state_d = state_q;
        if (mode_edge) begin
            unique case (state_q)
                StRun:     state_d = StSetHour;
                StSetHour: state_d = StSetMin;
                default:   state_d = StRun;
            endcase
        end

        if (state_d == StRun) begin
            phase_d = 1'b0;
        end else if (!in_run && bus.tick && !mode_edge) begin
            phase_d = !phase_q;
        end else begin
            phase_d = phase_q;
        end

        mask_d = MASK_NONE;
        if (phase_d && (state_d == StSetHour)) begin
            mask_d = MASK_HOUR;
        end else if (phase_d && (state_d == StSetMin)) begin
            mask_d = MASK_MIN;
        end

        day_carry_d = in_run && hour_wrap;
    end

    // Single state register: FSM, button history, blink phase and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            mode_hist_q <= 1'b1; // a button held through reset yields no edge
            inc_hist_q  <= 1'b1;
            phase_q     <= 1'b0;
            mask_q      <= MASK_NONE;
            day_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_hist_q <= bus.mode_btn;
            inc_hist_q  <= bus.inc_btn;
            phase_q     <= phase_d;
            mask_q      <= mask_d;
            day_carry_q <= day_carry_d;
        end
    end

    bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (run_adv),
        .clr   (sec_clr),
        .tens  (bus.sec1),
        .units (bus.sec0),
        .wrap  (sec_wrap)
    );

    bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .clr   (1'b0),
        .tens  (bus.min1),
        .units (bus.min0),
        .wrap  (min_wrap)
    );

    bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
        .clk   (clk),
        .reset (reset),
        .inc   (hour_inc),
        .clr   (1'b0),
        .tens  (bus.hour1),
        .units (bus.hour0),
        .wrap  (hour_wrap)
    );

    assign bus.blink_mask = mask_q;
    assign bus.day_carry  = day_carry_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter: a 24-hour instance (main sequence) and a
// 12-hour instance (hour wrap at 11).
module tb_time_of_day_counter;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;

    time_of_day_counter_if bus ();
    time_of_day_counter_if bus12 ();

    time_of_day_counter #(.HOUR_MOD(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    time_of_day_counter #(.HOUR_MOD(12)) dut12 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus12)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] hms();
        return {bus.hour1, bus.hour0, bus.min1, bus.min0, bus.sec1, bus.sec0};
    endfunction

    function automatic logic [23:0] hms12();
        return {bus12.hour1, bus12.hour0, bus12.min1, bus12.min0, bus12.sec1, bus12.sec0};
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse a button for one cycle on the selected instance, then let it settle low.
    task automatic press(input bit on12, input bit is_inc, input int n);
        for (int i = 0; i < n; i++) begin
            if (on12) begin
                if (is_inc) bus12.inc_btn = 1'b1; else bus12.mode_btn = 1'b1;
            end else begin
                if (is_inc) bus.inc_btn = 1'b1; else bus.mode_btn = 1'b1;
            end
            step();
            bus12.inc_btn = 1'b0; bus12.mode_btn = 1'b0;
            bus.inc_btn   = 1'b0; bus.mode_btn   = 1'b0;
            step();
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
        end
    endtask

    initial begin
        bus.tick = 1'b0;   bus.enable = 1'b0;   bus.mode_btn = 1'b1;   bus.inc_btn = 1'b1;
        bus12.tick = 1'b0; bus12.enable = 1'b0; bus12.mode_btn = 1'b0; bus12.inc_btn = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step(); step();
        // Buttons still held: reset state, no edge seen.
        check("reset_digits", hms(), 24'h000000);
        check("reset_mask", 24'(bus.blink_mask), 24'h0);
        check("reset_carry", 24'(bus.day_carry), 24'h0);
        ticks(1); // enable low: a set state would toggle blink here
        check("held_btn_still_run", 24'(bus.blink_mask), 24'h0);
        check("held_btn_digits", hms(), 24'h000000);
        bus.mode_btn = 1'b0; bus.inc_btn = 1'b0;
        step();

        // Preload 23:59:58 via set mode and ticks.
        press(0, 0, 1);
        press(0, 1, 23);
        check("set_hour_23", hms(), 24'h230000);
        press(0, 0, 1);
        press(0, 1, 59);
        check("set_min_59", hms(), 24'h235900);
        press(0, 0, 1);
        check("back_to_run_mask", 24'(bus.blink_mask), 24'h0);
        bus.enable = 1'b1;
        ticks(58);
        check("preload_235958", hms(), 24'h235958);
        ticks(1);
        check("run_235959", hms(), 24'h235959);
        check("no_carry_235959", 24'(bus.day_carry), 24'h0);
        ticks(1);
        check("rollover_digits", hms(), 24'h000000);
        check("rollover_carry", 24'(bus.day_carry), 24'h1);
        step();
        check("carry_one_cycle", 24'(bus.day_carry), 24'h0);

        // Enable gating.
        bus.enable = 1'b0;
        ticks(5);
        check("disabled_hold", hms(), 24'h000000);
        bus.enable = 1'b1;
        ticks(9);
        check("run_000009", hms(), 24'h000009);
        ticks(1);
        check("units_carry_000010", hms(), 24'h000010);

        // Reach 10:20:35.
        press(0, 0, 1);
        press(0, 1, 10);
        press(0, 0, 1);
        press(0, 1, 20);
        press(0, 0, 1);
        ticks(35);
        check("run_102035", hms(), 24'h102035);

        // SET_HOUR: seconds clear on entry, hour increments wrap without carry.
        press(0, 0, 1);
        check("enter_set_hour_sec_clr", hms(), 24'h102000);
        check("enter_set_hour_mask", 24'(bus.blink_mask), 24'h0);
        press(0, 1, 12);
        check("hour_22", hms(), 24'h222000);
        press(0, 1, 1);
        check("hour_23", hms(), 24'h232000);
        press(0, 1, 1);
        check("hour_wrap_00", hms(), 24'h002000);
        press(0, 1, 1);
        check("hour_01", hms(), 24'h012000);
        ticks(1);
        check("blink_hour_on", 24'(bus.blink_mask), 24'h30);
        ticks(1);
        check("blink_hour_off", 24'(bus.blink_mask), 24'h0);
        ticks(1);
        check("blink_hour_on2", 24'(bus.blink_mask), 24'h30);
        check("set_secs_frozen", hms(), 24'h012000);

        // Mode and inc in the same cycle: mode wins, hours untouched.
        bus.mode_btn = 1'b1; bus.inc_btn = 1'b1;
        step();
        bus.mode_btn = 1'b0; bus.inc_btn = 1'b0;
        check("mode_inc_same_mask", 24'(bus.blink_mask), 24'h0c);
        check("mode_inc_same_digits", hms(), 24'h012000);
        step();

        // SET_MIN: wrap 59 -> 00 without carrying into hours.
        press(0, 1, 38);
        check("min_58", hms(), 24'h015800);
        press(0, 1, 1);
        check("min_59", hms(), 24'h015900);
        press(0, 1, 1);
        check("min_wrap_no_carry", hms(), 24'h010000);
        ticks(1);
        check("blink_min_off", 24'(bus.blink_mask), 24'h0);
        press(0, 0, 1);
        check("set_min_to_run_mask", 24'(bus.blink_mask), 24'h0);
        ticks(1);
        check("run_after_set", hms(), 24'h010001);
        press(0, 1, 1);
        check("inc_ignored_in_run", hms(), 24'h010001);

        // Tick coincident with mode edge out of RUN is discarded.
        bus.mode_btn = 1'b1; bus.tick = 1'b1;
        step();
        bus.mode_btn = 1'b0; bus.tick = 1'b0;
        check("mode_tick_digits", hms(), 24'h010000);
        check("mode_tick_no_toggle", 24'(bus.blink_mask), 24'h0);
        step();
        ticks(1);
        check("in_set_hour_after", 24'(bus.blink_mask), 24'h30);

        // Reset mid-set returns to RUN at 00:00:00.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset_mid_set_digits", hms(), 24'h000000);
        check("reset_mid_set_mask", 24'(bus.blink_mask), 24'h0);
        check("reset_mid_set_carry", 24'(bus.day_carry), 24'h0);
        ticks(1);
        check("run_after_reset", hms(), 24'h000001);

        // 12-hour build: hours wrap 11 -> 00.
        press(1, 0, 1);
        press(1, 1, 11);
        check("h12_hour_11", hms12(), 24'h110000);
        press(1, 1, 1);
        check("h12_hour_wrap", hms12(), 24'h000000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
